// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port DataMemory between the load/store
// unit (port 0) and the program/debug loader (port 1). Each winning request
// spends one ISSUE cycle on the memory pins; reads then wait RD_LAT cycles
// in RDWAIT and flag the owner's rvalid in the last of them.
// Optional feature: define DMEM_RR_ARB_EN for round-robin tie-breaking;
// otherwise port 0 always wins a tie.
module dmem_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  we0,
  input  logic [3:0]  we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata,
  output logic [3:0]  wea,
  output logic [31:0] addra,
  output logic [31:0] dina,
  input  logic [31:0] douta
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        own_q, own_d;     // port that owns the transaction in flight
  logic        wr_q, wr_d;       // transaction in flight is a write
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        rv0_q, rv0_d, rv1_q, rv1_d;
  logic [3:0]  wea_q, wea_d;
  logic [31:0] addra_q, addra_d, dina_q, dina_d;
  logic        arb;              // this edge is an arbitration point
  logic        win1;             // port 1 wins if this edge grants
  logic        unused_addr_lsbs;

  // Byte offset inside a word is irrelevant to a word-wide memory.
  assign unused_addr_lsbs = ^{addr0[1:0], addr1[1:0]};

  assign arb = (state_q == IDLE)
            || (state_q == ISSUE  && wr_q)
            || (state_q == RDWAIT && cnt_q == 3'd1);

`ifdef DMEM_RR_ARB_EN
  logic last_q, last_d;          // last grant went to port 1

  // On a tie, the port that did not win the most recent grant goes first.
  assign win1 = req1 & (~req0 | ~last_q);

  // Remember the winner of every grant.
  always_comb begin
    last_d = last_q;
    if (arb && (req0 || req1)) last_d = win1;
  end

  // Last-winner register; reset says port 1 went last so port 0 leads.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  // Fixed priority: port 0 always beats port 1.
  assign win1 = req1 & ~req0;
`endif

  // Next-state, arbitration and registered memory-pin/handshake values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    wr_d    = wr_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    wea_d   = 4'h0;
    addra_d = addra_q;
    dina_d  = dina_q;

    case (state_q)
      ISSUE: begin
        if (!wr_q) begin
          state_d = RDWAIT;
          cnt_d   = 3'(RD_LAT);
        end
      end
      RDWAIT: begin
        if (cnt_q != 3'd1) cnt_d = cnt_q - 3'd1;
      end
      default: ;
    endcase

    if (arb) begin
      if (req0 || req1) begin
        state_d = ISSUE;
        own_d   = win1;
        gnt0_d  = ~win1;
        gnt1_d  = win1;
        wea_d   = win1 ? we1 : we0;
        wr_d    = win1 ? (we1 != 4'h0) : (we0 != 4'h0);
        addra_d = {2'b00, (win1 ? addr1[31:2] : addr0[31:2])};
        dina_d  = win1 ? wdata1 : wdata0;
      end else begin
        state_d = IDLE;
      end
    end

    // rvalid marks the final RDWAIT cycle, when douta carries the read word.
    rv0_d = (state_d == RDWAIT) && (cnt_d == 3'd1) && !own_d;
    rv1_d = (state_d == RDWAIT) && (cnt_d == 3'd1) &&  own_d;
  end

  // State and output registers; reset abandons any read in flight.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      own_q   <= 1'b0;
      wr_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      wea_q   <= 4'h0;
      addra_q <= 32'h0;
      dina_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      wr_q    <= wr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      wea_q   <= wea_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign rvalid0 = rv0_q;
  assign rvalid1 = rv1_q;
  assign wea     = wea_q;
  assign addra   = addra_q;
  assign dina    = dina_q;
  assign rdata   = douta;

endmodule
